majority_window: RTL and testbench

MAJORITY_WINDOW -- requirements
Module: majority_window

---
 rtl/majority_pkg.sv | 15 +
 rtl/majority_lane.sv | 57 +++++
 rtl/majority_window.sv | 123 ++++++++++++
 tb/tb_majority_window.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/majority_pkg.sv
// Shared types and helpers for the majority_window block: the window fill state
// and the per-lane count width.
package majority_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } fill_state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/majority_lane.sv
// One channel of majority_window: a W-deep bit history, its running count of
// ones and the combinational majority/tie decision on the post-update window.
module majority_lane
  import majority_pkg::*;
#(
  parameter int W        = 5,
  parameter int CW       = cnt_w(W),
  parameter bit TIE_HIGH = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          accept,
  input  logic          drop_oldest,
  input  logic          din,
  input  logic [CW-1:0] fill_upd,
  output logic          maj,
  output logic          tie
);

  logic [W-1:0]  hist;
  logic [W-1:0]  hist_upd;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_upd;
  logic [CW:0]   twice_cnt;
  logic [CW:0]   fill_ext;

  generate
    if (W == 1) begin : g_single
      assign hist_upd = din;
    end else begin : g_shift
      assign hist_upd = {hist[W-2:0], din};
    end
  endgenerate

  // hist[W-1] is the sample leaving the window, but only once the window is full.
  assign cnt_upd = cnt + CW'(din) - CW'(drop_oldest & hist[W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      cnt  <= '0;
    end else if (clr) begin
      hist <= '0;
      cnt  <= '0;
    end else if (accept) begin
      hist <= hist_upd;
      cnt  <= cnt_upd;
    end
  end

  assign twice_cnt = {cnt_upd, 1'b0};
  assign fill_ext  = {1'b0, fill_upd};
  assign tie       = (twice_cnt == fill_ext);
  assign maj       = (twice_cnt > fill_ext) | (tie & TIE_HIGH);

endmodule

// File: rtl/majority_window.sv
// Per-channel sliding-window majority vote with valid/ready handshakes.
// Define MAJORITY_WINDOW_STATS_EN to add the saturating stat_ties counter port.
module majority_window
  import majority_pkg::*;
#(
  parameter int N        = 8,
  parameter int W        = 5,
  parameter int TIE_HIGH = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_maj,
  output logic [N-1:0] out_tie,
  output logic         out_full
`ifdef MAJORITY_WINDOW_STATS_EN
  ,
  output logic [15:0]  stat_ties
`endif
);

  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] FILL_LAST = CW'(W - 1);

  fill_state_e   state_q;
  fill_state_e   state_d;
  logic [CW-1:0] fill_q;
  logic [CW-1:0] fill_upd;
  logic          win_full;
  logic          accept;
  logic [N-1:0]  maj_d;
  logic [N-1:0]  tie_d;

  assign in_ready = (!out_valid | out_ready) & !clr;
  assign accept   = in_valid & in_ready;

  // Fill state and fill count only move on an accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      fill_q  <= '0;
    end else if (clr) begin
      state_q <= EMPTY;
      fill_q  <= '0;
    end else if (accept) begin
      state_q <= state_d;
      fill_q  <= fill_upd;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   state_d = (W == 1) ? FULL : FILLING;
      FILLING: state_d = (fill_q == FILL_LAST) ? FULL : FILLING;
      FULL:    state_d = FULL;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    win_full = (state_q == FULL);
    fill_upd = win_full ? fill_q : fill_q + CW'(1);
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    majority_lane #(
      .W        (W),
      .CW       (CW),
      .TIE_HIGH (TIE_HIGH != 0)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .accept      (accept),
      .drop_oldest (win_full),
      .din         (in_data[i]),
      .fill_upd    (fill_upd),
      .maj         (maj_d[i]),
      .tie         (tie_d[i])
    );
  end

  // A new accept overwrites a result being handed off in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_maj   <= '0;
      out_tie   <= '0;
      out_full  <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      out_maj   <= '0;
      out_tie   <= '0;
      out_full  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_maj   <= maj_d;
      out_tie   <= tie_d;
      out_full  <= (state_d == FULL);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MAJORITY_WINDOW_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ties <= '0;
    end else if (clr) begin
      stat_ties <= '0;
    end else if (accept && (|tie_d) && (stat_ties != 16'hFFFF)) begin
      stat_ties <= stat_ties + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_majority_window.sv
// Self-checking bench for majority_window (N=8, W=5): a queue-based window model
// checked every cycle, plus directed sequences pinned with literal expectations.
module tb_majority_window;

  localparam int N = 8;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic [N-1:0] in_data = '0;
  logic         out_ready = 1'b0;

  logic         in_ready0, out_valid0, out_full0;
  logic [N-1:0] out_maj0, out_tie0;
  logic         in_ready1, out_valid1, out_full1;
  logic [N-1:0] out_maj1, out_tie1;
`ifdef MAJORITY_WINDOW_STATS_EN
  logic [15:0]  stat_ties0, stat_ties1;
`endif

  int compared = 0;
  int mismatched = 0;

  // Model state: the live window as a queue of samples plus the pending result.
  logic [N-1:0] win[$];
  logic         exp_valid = 1'b0;
  logic [N-1:0] exp_maj0 = '0, exp_maj1 = '0, exp_tie = '0;
  logic         exp_full = 1'b0;
  int           exp_stat = 0;

  always #5 clk = ~clk;

  majority_window #(.N(N), .W(W), .TIE_HIGH(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_maj(out_maj0), .out_tie(out_tie0), .out_full(out_full0)
`ifdef MAJORITY_WINDOW_STATS_EN
    , .stat_ties(stat_ties0)
`endif
  );

  majority_window #(.N(N), .W(W), .TIE_HIGH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_maj(out_maj1), .out_tie(out_tie1), .out_full(out_full1)
`ifdef MAJORITY_WINDOW_STATS_EN
    , .stat_ties(stat_ties1)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Checker: at each falling edge compare registered outputs with the model,
  // then advance the model with the inputs the next rising edge will sample.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        win.delete();
        exp_valid = 1'b0;
        exp_stat  = 0;
        checkOutput("rst out_valid", {62'd0, out_valid0, out_valid1}, 64'd0);
        checkOutput("rst out_maj", {out_maj0, out_maj1}, 64'd0);
        checkOutput("rst out_tie", {out_tie0, out_tie1}, 64'd0);
        checkOutput("rst out_full", {62'd0, out_full0, out_full1}, 64'd0);
      end else begin
        logic rdy;
        logic [N-1:0] m0, m1, t;
        int f, c;
        rdy = (!exp_valid || out_ready) && !clr;
        checkOutput("in_ready", {62'd0, in_ready0, in_ready1}, {62'd0, rdy, rdy});
        checkOutput("out_valid", {62'd0, out_valid0, out_valid1}, {62'd0, exp_valid, exp_valid});
        if (exp_valid) begin
          checkOutput("out_maj th0", out_maj0, exp_maj0);
          checkOutput("out_maj th1", out_maj1, exp_maj1);
          checkOutput("out_tie", {out_tie0, out_tie1}, {exp_tie, exp_tie});
          checkOutput("out_full", {62'd0, out_full0, out_full1}, {62'd0, exp_full, exp_full});
        end
`ifdef MAJORITY_WINDOW_STATS_EN
        checkOutput("stat_ties", {stat_ties0, stat_ties1}, {exp_stat[15:0], exp_stat[15:0]});
`endif
        if (clr) begin
          win.delete();
          exp_valid = 1'b0;
          exp_stat  = 0;
        end else if (in_valid && rdy) begin
          win.push_back(in_data);
          if (win.size() > W) void'(win.pop_front());
          f = win.size();
          for (int i = 0; i < N; i++) begin
            c = 0;
            foreach (win[k]) c += int'(win[k][i]);
            t[i]  = (2 * c == f);
            m0[i] = (2 * c > f);
            m1[i] = (2 * c >= f);
          end
          exp_valid = 1'b1;
          exp_maj0  = m0;
          exp_maj1  = m1;
          exp_tie   = t;
          exp_full  = (f == W);
          if (t != '0 && exp_stat < 65535) exp_stat++;
        end else if (out_ready) begin
          exp_valid = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [N-1:0] d);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic doClear();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    logic [N-1:0] seq[8];
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("pin reset in_ready", {63'd0, in_ready0}, 64'd1);
    checkOutput("pin reset out_valid", {63'd0, out_valid0}, 64'd0);

    for (int k = 1; k <= 5; k++) begin
      applyStimulus(8'hFF);
      checkOutput("pin ff out_valid", {63'd0, out_valid0}, 64'd1);
      checkOutput("pin ff out_maj", {56'd0, out_maj0}, 64'hFF);
      checkOutput("pin ff out_tie", {56'd0, out_tie0}, 64'h0);
      checkOutput("pin ff out_full", {63'd0, out_full0}, (k == 5) ? 64'd1 : 64'd0);
    end

    doClear();
    seq = '{8'hF0, 8'hF0, 8'hF0, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h00};
    for (int k = 0; k < 5; k++) applyStimulus(seq[k]);
    checkOutput("pin f0 out_maj", {56'd0, out_maj0}, 64'hF0);
    checkOutput("pin f0 out_tie", {56'd0, out_tie0}, 64'h0);
    checkOutput("pin f0 out_full", {63'd0, out_full0}, 64'd1);

    doClear();
    applyStimulus(8'hFF);
    applyStimulus(8'h00);
    checkOutput("pin tie out_tie", {56'd0, out_tie0}, 64'hFF);
    checkOutput("pin tie out_maj th0", {56'd0, out_maj0}, 64'h00);
    checkOutput("pin tie out_maj th1", {56'd0, out_maj1}, 64'hFF);
`ifdef MAJORITY_WINDOW_STATS_EN
    checkOutput("pin tie stat_ties", {48'd0, stat_ties0}, 64'd1);
`endif

    doClear();
    for (int k = 0; k < 5; k++) applyStimulus(8'hFF);
    applyStimulus(8'h00);
    checkOutput("pin wrap 6th", {56'd0, out_maj0}, 64'hFF);
    applyStimulus(8'h00);
    checkOutput("pin wrap 7th", {56'd0, out_maj0}, 64'hFF);
    applyStimulus(8'h00);
    checkOutput("pin wrap 8th", {56'd0, out_maj0}, 64'h00);

    // Stall with out_ready low, then stream back-to-back.
    doClear();
    applyStimulus(8'h3C);
    in_valid = 1'b1; in_data = 8'hC3; out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("pin stall in_ready", {63'd0, in_ready0}, 64'd0);
      checkOutput("pin stall out_maj", {56'd0, out_maj0}, 64'h3C);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput("pin stream out_valid", {63'd0, out_valid0}, 64'd1);
      in_data = 8'(k * 37 + 5);
    end
    in_valid = 1'b0;

    doClear();
    for (int k = 0; k < 3; k++) applyStimulus(8'h55);
    doClear();
    checkOutput("pin clr out_valid", {63'd0, out_valid0}, 64'd0);
    applyStimulus(8'hAA);
    checkOutput("pin clr aa maj", {56'd0, out_maj0}, 64'hAA);
    checkOutput("pin clr aa full", {63'd0, out_full0}, 64'd0);

    for (int k = 0; k < 3; k++) applyStimulus(8'h55);
    rst_n = 1'b0;
    #1 checkOutput("pin rst out_valid", {63'd0, out_valid0}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    applyStimulus(8'hAA);
    checkOutput("pin rst aa maj", {56'd0, out_maj0}, 64'hAA);
    checkOutput("pin rst aa full", {63'd0, out_full0}, 64'd0);

    // Random traffic with occasional clears and resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(3) != 0);
      clr       = ($urandom_range(79) == 0);
      if ($urandom_range(499) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; clr = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
